piso_tx: RTL and testbench
==========================

# piso_tx

Parallel-in serial-out transmitter that sits directly upstream of the 4-bit serial-in shift register. It accepts a WIDTH-bit word through a valid/ready handshake and drives it out one bit per enabled clock on `so`, with `so_valid` and `so_last` qualifiers, so the downstream shift register holds the complete word after WIDTH enabled cycles. Back-to-back words stream without gap cycles.

## Interface
- `WIDTH`, 4: bits per word; legal range 2..32.
- `MSB_FIRST`, 1: 1 transmits `pdata[WIDTH-1]` first, so the first bit lands in the downstream `d[3]`; 0 transmits `pdata[0]` first.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset. Synchronous, active-low.
- `pdata` input WIDTH: parallel word, sampled on the accept edge.
- `pvalid` input 1: `pdata` is valid.
- `pready` output 1: block can accept a word this cycle.
- `so_en` input 1: downstream consumes the current bit at this edge.
- `so` output 1: serial data bit.
- `so_valid` output 1: `so` carries a word bit.
- `so_last` output 1: current bit is the final bit of the word.

## Operation
- FSM has two states:
  - IDLE: `so_valid`=0 and `pready`=1.
  - SHIFT: `so_valid`=1.
- Internal registers: shift register `sr[WIDTH-1:0]` and bit counter `cnt` of width clog2(WIDTH). `cnt` counts bits already consumed.
- Accept condition is `pvalid && pready` at the rising edge. On accept:
  - `sr` ← `pdata`, `cnt` ← 0, state → SHIFT.
- Bit output in SHIFT:
  - `so` = `sr[WIDTH-1]` when MSB_FIRST=1, else `sr[0]`.
  - On each edge with `so_en`=1, `sr` shifts toward the output end, zero-filling, and `cnt` increments.
- `so_last` = SHIFT && `cnt`==WIDTH-1.
- `pready` = `rst` && (IDLE || (`so_last` && `so_en`)). It is combinational from state and `so_en`, and is 0 while `rst` is low.
- Edge with `so_last` && `so_en`:
  - If a word is accepted in the same edge, load the new word and stay in SHIFT. No bubble.
  - Otherwise go to IDLE.
- `so_en`=0 in SHIFT: `so`, `so_valid`, `so_last`, `sr` and `cnt` hold.
- In IDLE, `so_en` is ignored and `so`=0.
- `pdata` is ignored unless accepted. `pvalid` without `pready` has no effect.
- Reset mid-word: the word is discarded, no partial output. The first clock edge with `rst` low forces IDLE, `sr`=0, `cnt`=0.

## Timing
- Reset values: `so`=0, `so_valid`=0, `so_last`=0; `pready`=0 while `rst`=0, then 1 in the first cycle after release.
- Latency: the first bit is valid in the cycle after the accept edge.
- One word takes exactly WIDTH enabled cycles. With `so_en` tied high, throughput is one word per WIDTH cycles.
- All outputs except `pready` are registered.
- Required downstream connection: the downstream shift register's `si` is driven by `so`, and its clock is gated or enabled by `so_valid && so_en`.

## Structure
- Shared package `piso_pkg`:
  - state enum `{IDLE, SHIFT}`;
  - constant `CNT_W` = clog2(WIDTH) as a function;
  - default `WIDTH` = 4, matching the downstream 4-bit register.
- Single module, no sub-modules.
- A bench-only top `piso_sipo_link` instantiates `piso_tx` driving the existing 4-bit shift register, for end-to-end checks.

## Test plan
- Single word, WIDTH=4, MSB_FIRST=1, `so_en`=1, `pdata`=4'b1011 → `so`=1,0,1,1 on cycles 1–4 after accept; `so_last` only on cycle 4; downstream register `{d[3],d[2],d[1],d[0]}`=1011.
- Back-to-back: 4'hA accepted, `pvalid` held with 4'h5 → `pready`=1 on cycle 4 and `so`=1,0,1,0,0,1,0,1 on 8 contiguous `so_valid` cycles with no gap.
- Stall: `pdata`=4'b1100, `so_en`=0 on cycles 2–4 → `so` holds 1 and `so_valid`=1 throughout; the word completes on cycle 7 with `so_last` on the final 0.
- Reset mid-word: `rst`=0 at edge 2 of word 4'hF → next cycle `so`=0, `so_valid`=0, `pready`=0; after release `pready`=1 and no residual bits appear.
- LSB-first: MSB_FIRST=0, `pdata`=4'b0001 → `so`=1,0,0,0; `pvalid` while SHIFT and not last → word not accepted and `pready`=0.

Source files
------------

// File: rtl/piso_pkg.sv
// piso_pkg: shared types and sizing helpers for the parallel-in serial-out transmitter
package piso_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam int DEFAULT_WIDTH = 4;
    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction
endpackage

// File: rtl/piso_tx.sv
// piso_tx: streams WIDTH-bit words out one bit per enabled clock with valid/last qualifiers
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pdata,
    input  logic             pvalid,
    output logic             pready,
    input  logic             so_en,
    output logic             so,
    output logic             so_valid,
    output logic             so_last
);
    localparam int CNT_W = cnt_w(WIDTH);
    state_t           state, state_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             accept;
    assign so_valid = state == SHIFT;
    assign so_last  = so_valid && cnt == CNT_W'(WIDTH - 1);
    assign so       = MSB_FIRST ? sr[WIDTH-1] : sr[0];
    assign pready   = rst && (state == IDLE || (so_last && so_en));
    assign accept   = pvalid && pready;
    // next state: load on accept (also on the last bit, so words chain with no bubble), else shift when enabled
    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        if (accept) begin
            state_n = SHIFT;
            sr_n    = pdata;
            cnt_n   = '0;
        end else if (state == SHIFT && so_en) begin
            sr_n    = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
            cnt_n   = so_last ? '0 : cnt + 1'b1;
            state_n = so_last ? IDLE : SHIFT;
        end
    end
    // state registers; active-low reset drops any partially sent word
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            sr    <= sr_n;
            cnt   <= cnt_n;
        end
    end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: scoreboard bench for piso_tx in MSB-first and LSB-first builds
module tb_piso_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] pdata0 = '0, pdata1 = '0;
    logic       pvalid0 = 1'b0, pvalid1 = 1'b0;
    logic       so_en0 = 1'b1, so_en1 = 1'b1;
    logic       pready0, so0, so_valid0, so_last0;
    logic       pready1, so1, so_valid1, so_last1;
    logic [3:0] d0 = '0;
    logic [1:0] q0[$], q1[$];
    int         checks = 0, errors = 0;

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst(rst), .pdata(pdata0), .pvalid(pvalid0), .pready(pready0),
        .so_en(so_en0), .so(so0), .so_valid(so_valid0), .so_last(so_last0)
    );
    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst(rst), .pdata(pdata1), .pvalid(pvalid1), .pready(pready1),
        .so_en(so_en1), .so(so1), .so_valid(so_valid1), .so_last(so_last1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // push expected bits at every accept edge; reset discards pending bits
    always @(posedge clk) begin
        if (!rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (pvalid0 && pready0)
                for (int i = 0; i < 4; i++) q0.push_back({i == 3, pdata0[3-i]});
            if (pvalid1 && pready1)
                for (int i = 0; i < 4; i++) q1.push_back({i == 3, pdata1[i]});
        end
    end

    // pop and compare each consumed bit; model the downstream 4-bit register
    always @(negedge clk) begin
        logic [1:0] e;
        if (so_valid0 && so_en0) begin
            if (q0.size() == 0) check("so0_extra", 1, 0);
            else begin
                e = q0.pop_front();
                check("so0", so0, e[0]);
                check("so0_last", so_last0, e[1]);
                d0 = {d0[2:0], so0};
            end
        end
        if (!so_valid0) check("so0_idle", {so0, so_last0}, 0);
        if (so_valid1 && so_en1) begin
            if (q1.size() == 0) check("so1_extra", 1, 0);
            else begin
                e = q1.pop_front();
                check("so1", so1, e[0]);
                check("so1_last", so_last1, e[1]);
            end
        end
    end

    initial begin
        repeat (3) tick();
        check("rst_so", so0, 0);
        check("rst_valid", so_valid0, 0);
        check("rst_last", so_last0, 0);
        check("rst_pready", pready0, 0);
        rst = 1'b1;
        #1;
        check("rel_pready", pready0, 1);
        // single word
        pdata0 = 4'b1011; pvalid0 = 1'b1;
        check("pre_valid", so_valid0, 0);
        tick();
        pvalid0 = 1'b0; pdata0 = 4'h0;
        check("lat_valid", so_valid0, 1);
        repeat (4) tick();
        check("single_idle", so_valid0, 0);
        check("single_d", d0, 4'b1011);
        // back-to-back
        pdata0 = 4'hA; pvalid0 = 1'b1;
        tick();
        pdata0 = 4'h5;
        for (int c = 1; c <= 4; c++) begin
            check("b2b_pready", pready0, c == 4);
            tick();
        end
        pvalid0 = 1'b0; pdata0 = 4'h0;
        for (int c = 5; c <= 8; c++) begin
            check("b2b_gap", so_valid0, 1);
            tick();
        end
        check("b2b_idle", so_valid0, 0);
        check("b2b_d", d0, 4'h5);
        // stall
        pdata0 = 4'b1100; pvalid0 = 1'b1;
        tick();
        pvalid0 = 1'b0;
        tick();
        so_en0 = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            #1;
            check("stall_so", so0, 1);
            check("stall_valid", so_valid0, 1);
            check("stall_last", so_last0, 0);
            check("stall_pready", pready0, 0);
            tick();
        end
        so_en0 = 1'b1;
        repeat (2) tick();
        check("stall_last7", so_last0, 1);
        tick();
        check("stall_idle", so_valid0, 0);
        check("stall_d", d0, 4'b1100);
        // reset mid-word
        pdata0 = 4'hF; pvalid0 = 1'b1;
        tick();
        pvalid0 = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("mid_pready_lo", pready0, 0);
        tick();
        check("mid_so", so0, 0);
        check("mid_valid", so_valid0, 0);
        check("mid_pready", pready0, 0);
        rst = 1'b1;
        #1;
        check("mid_rel_pready", pready0, 1);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("mid_residual", so_valid0, 0);
        end
        // LSB first with pvalid held mid-word
        pdata1 = 4'b0001; pvalid1 = 1'b1;
        tick();
        pdata1 = 4'hE;
        for (int c = 1; c <= 2; c++) begin
            check("lsb_pready", pready1, 0);
            tick();
        end
        pvalid1 = 1'b0;
        repeat (2) tick();
        check("lsb_idle", so_valid1, 0);
        repeat (4) tick();
        check("lsb_noaccept", so_valid1, 0);
        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
